// File: rtl/vram_scanout.sv
// vram_scanout: LCD scan-out engine. Generates panel timing and fetches
// RGB332 pixels from the framebuffer BSRAM read port. Each stored pixel
// covers a 2x2 block on the panel. Each pixel is expanded to RGB565.
//
// Ports:
//   clk          pixel clock (same clock as the BSRAM read port)
//   reset        synchronous, active-high
//   vram_addr    framebuffer byte address (BSRAM adb)
//   vram_ce      framebuffer read enable (BSRAM ceb)
//   vram_dout    BSRAM read data, RGB332, one cycle after the address
//   lcd_de       data enable, high on visible pixels
//   lcd_hsync    horizontal sync, active-low
//   lcd_vsync    vertical sync, active-low
//   lcd_r/g/b    RGB565 pixel data, zero outside visible pixels
//   vblank       line counter at or above V_ACTIVE (registered once)
//   frame_start  one-cycle pulse with the first lcd_de of a frame
//
// Optional build macro: VRAM_SCANOUT_CE_GATE_EN. When defined, reads are
// issued only for the even pixel of each horizontal pair and the colour
// register holds for the odd pixel. The LCD pins are identical in both builds.

module vram_scanout #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 43,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 8,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 12,
  parameter int unsigned FB_WIDTH = H_ACTIVE / 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] vram_addr,
  output logic        vram_ce,
  input  logic [7:0]  vram_dout,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned ROW_W   = 16;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ROW_W-1:0] FB_STEP  = ROW_W'(FB_WIDTH);

  // Elaboration-time geometry checks
  if (FB_WIDTH * (V_ACTIVE / 2) > 32768) begin : g_fb_too_big
    $error("vram_scanout: framebuffer FB_WIDTH*V_ACTIVE/2 exceeds 32768 bytes");
  end
  if ((H_ACTIVE % 2 != 0) || (V_ACTIVE % 2 != 0)) begin : g_odd_active
    $error("vram_scanout: H_ACTIVE and V_ACTIVE must be even");
  end

  // ---------------- Stage 0: counters and row-base accumulator
  logic [H_W-1:0]   h;
  logic [V_W-1:0]   v;
  logic [ROW_W-1:0] row_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v        <= '0;
        row_base <= '0;
      end else begin
        v <= v + V_W'(1);
        // Leaving the odd line of a pair advances to the next framebuffer row;
        // frozen during vertical blanking so it never exceeds the buffer.
        if (v[0] && (v < V_ACT_END)) begin
          row_base <= row_base + FB_STEP;
        end
      end
    end else begin
      h <= h + H_W'(1);
    end
  end

  // Stage-0 decodes
  logic              act0;
  logic              ce0;
  logic              hs0;
  logic              vs0;
  logic              fs0;
  logic              vb0;
  logic [ADDR_W-1:0] addr0;

  assign act0  = (h < H_ACT_END) && (v < V_ACT_END);
  assign hs0   = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
  assign vs0   = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
  assign fs0   = (h == '0) && (v == '0);
  assign vb0   = (v >= V_ACT_END);
  assign addr0 = ADDR_W'(row_base + ROW_W'(h >> 1));

`ifdef VRAM_SCANOUT_CE_GATE_EN
  assign ce0 = act0 && !h[0];
`else
  assign ce0 = act0;
`endif

  // ---------------- Stage 1: BSRAM request plus control pipeline
  // Sync flags travel active-high so every pipeline register clears to 0.
  logic de1, hs1, vs1, fs1;
  logic de2, hs2, vs2, fs2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr <= '0;
      vram_ce   <= 1'b0;
      vblank    <= 1'b0;
      de1       <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      fs1       <= 1'b0;
    end else begin
      vram_ce <= ce0;
      if (ce0) begin
        vram_addr <= addr0;
      end
      vblank <= vb0;
      de1    <= act0;
      hs1    <= hs0;
      vs1    <= vs0;
      fs1    <= fs0;
    end
  end

  // ---------------- Stage 2: BSRAM data cycle, controls delayed to match
  always_ff @(posedge clk) begin
    if (reset) begin
      de2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      fs2 <= 1'b0;
    end else begin
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      fs2 <= fs1;
    end
  end

`ifdef VRAM_SCANOUT_CE_GATE_EN
  // Pair parity, so the colour register loads only from the even pixel's read
  logic even1, even2;

  always_ff @(posedge clk) begin
    if (reset) begin
      even1 <= 1'b0;
      even2 <= 1'b0;
    end else begin
      even1 <= !h[0];
      even2 <= even1;
    end
  end
`endif

  // RGB332 -> RGB565 by bit replication
  logic [4:0] r_x;
  logic [5:0] g_x;
  logic [4:0] b_x;

  assign r_x = {vram_dout[7:5], vram_dout[7:6]};
  assign g_x = {vram_dout[4:2], vram_dout[4:2]};
  assign b_x = {vram_dout[1:0], vram_dout[1:0], vram_dout[1]};

  // ---------------- Stage 3: LCD output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      frame_start <= 1'b0;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
    end else begin
      lcd_de      <= de2;
      lcd_hsync   <= !hs2;
      lcd_vsync   <= !vs2;
      frame_start <= fs2;
      if (!de2) begin
        lcd_r <= '0;
        lcd_g <= '0;
        lcd_b <= '0;
      end
`ifdef VRAM_SCANOUT_CE_GATE_EN
      else if (even2) begin
`else
      else begin
`endif
        lcd_r <= r_x;
        lcd_g <= g_x;
        lcd_b <= b_x;
      end
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout with a reduced panel geometry so several frames fit
// in a short run. An arithmetic model derives every output from the cycle
// index since reset release; directed literal checks pin the model.

module tb_vram_scanout;

  localparam int HA  = 16;
  localparam int HFP = 3;
  localparam int HS  = 2;
  localparam int HBP = 4;
  localparam int VA  = 8;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int FBW = HA / 2;
  localparam int HT  = HA + HFP + HS + HBP;   // 25
  localparam int VT  = VA + VFP + VS + VBP;   // 15
  localparam int FT  = HT * VT;               // 375

`ifdef VRAM_SCANOUT_CE_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] vram_addr;
  logic        vram_ce;
  logic [7:0]  vram_dout = 8'h00;
  logic        lcd_de, lcd_hsync, lcd_vsync, vblank, frame_start;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;

  int errors = 0;
  int checks = 0;
  int k = 0;        // cycles since the last clock edge that sampled reset

  logic [7:0] mem [0:32767];

  always #5 clk = ~clk;

  vram_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FB_WIDTH(FBW)
  ) dut (
    .clk(clk), .reset(reset),
    .vram_addr(vram_addr), .vram_ce(vram_ce), .vram_dout(vram_dout),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .vblank(vblank), .frame_start(frame_start)
  );

  // Framebuffer BSRAM read port, one-cycle latency, output holds when idle
  always @(posedge clk) begin
    if (vram_ce) vram_dout <= mem[vram_addr];
  end

  always @(posedge clk) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  // ---------------- Model: position, address and colour from arithmetic
  function automatic int hp(input int c); return c % HT; endfunction
  function automatic int vp(input int c); return (c / HT) % VT; endfunction
  function automatic bit visible(input int c);
    return (hp(c) < HA) && (vp(c) < VA);
  endfunction
  function automatic int pix_addr(input int c);
    return (vp(c) / 2) * FBW + hp(c) / 2;
  endfunction
  // Full-scale rescale of each channel, rounded to nearest
  function automatic int red5(input logic [7:0] d);
    return (int'(d[7:5]) * 31 + 3) / 7;
  endfunction
  function automatic int grn6(input logic [7:0] d);
    return int'(d[4:2]) * 63 / 7;
  endfunction
  function automatic int blu5(input logic [7:0] d);
    return (int'(d[1:0]) * 31 + 1) / 3;
  endfunction

  // ---------------- Per-cycle compare against the model
  int  exp_addr = 0;
  int  ce_cnt = 0;
  always @(negedge clk) begin
    int c1, c3, e_ce, e_vb, e_de, e_hs, e_vs, e_fs, e_r, e_g, e_b;
    logic [7:0] px;
    c1 = k - 1;
    c3 = k - 3;
    e_ce = (k >= 1 && visible(c1) && (!GATE || (hp(c1) % 2 == 0))) ? 1 : 0;
    if (k == 0) exp_addr = 0;
    else if (e_ce == 1) exp_addr = pix_addr(c1);
    e_vb = (k >= 1 && vp(c1) >= VA) ? 1 : 0;
    if (k >= 3) begin
      e_de = visible(c3) ? 1 : 0;
      e_hs = (hp(c3) >= HA + HFP && hp(c3) < HA + HFP + HS) ? 0 : 1;
      e_vs = (vp(c3) >= VA + VFP && vp(c3) < VA + VFP + VS) ? 0 : 1;
      e_fs = (c3 % FT == 0) ? 1 : 0;
      px   = mem[15'(pix_addr(c3))];
      e_r  = e_de ? red5(px) : 0;
      e_g  = e_de ? grn6(px) : 0;
      e_b  = e_de ? blu5(px) : 0;
    end else begin
      e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_r = 0; e_g = 0; e_b = 0;
    end
    chk("vram_ce", int'(vram_ce), e_ce);
    chk("vram_addr", int'(vram_addr), exp_addr);
    chk("vblank", int'(vblank), e_vb);
    chk("lcd_de", int'(lcd_de), e_de);
    chk("lcd_hsync", int'(lcd_hsync), e_hs);
    chk("lcd_vsync", int'(lcd_vsync), e_vs);
    chk("frame_start", int'(frame_start), e_fs);
    chk("lcd_r", int'(lcd_r), e_r);
    chk("lcd_g", int'(lcd_g), e_g);
    chk("lcd_b", int'(lcd_b), e_b);
    // Reads issued during the first line
    if (k == 0) ce_cnt = 0;
    else if (k <= HT) ce_cnt += int'(vram_ce);
    if (k == HT + 1) chk("ce_per_line", ce_cnt, GATE ? HA / 2 : HA);
  end

  // Bounded wait until the cycle index reaches t (sampled on negedge)
  task automatic wait_k(input int t);
    int n = 0;
    while (k != t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (k != t) chk("wait_timeout", k, t);
  endtask

  task automatic chk_rgb(input string name, input int r, input int g, input int b);
    chk({name, "_r"}, int'(lcd_r), r);
    chk({name, "_g"}, int'(lcd_g), g);
    chk({name, "_b"}, int'(lcd_b), b);
  endtask

  // ---------------- Directed stimulus with hand-computed expectations
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    mem[2] = 8'h03;
    mem[3] = 8'hFF;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hsync", int'(lcd_hsync), 1);
    chk("rst_vsync", int'(lcd_vsync), 1);
    chk("rst_de", int'(lcd_de), 0);
    chk("rst_ce", int'(vram_ce), 0);
    chk_rgb("rst", 0, 0, 0);
    reset = 1'b0;

    wait_k(1);  chk("k1_ce", int'(vram_ce), 1); chk("k1_addr", int'(vram_addr), 0);
    wait_k(2);  chk("k2_de", int'(lcd_de), 0);
    wait_k(3);  chk("k3_de", int'(lcd_de), 1); chk("k3_fs", int'(frame_start), 1);
    chk_rgb("px0", 31, 0, 0);
    wait_k(4);  chk_rgb("px1", 31, 0, 0); chk("k4_fs", int'(frame_start), 0);
    wait_k(5);  chk_rgb("px2", 0, 63, 0);
    wait_k(6);  chk_rgb("px3", 0, 63, 0);
    wait_k(7);  chk_rgb("px4", 0, 0, 31);
    wait_k(9);  chk_rgb("px6", 31, 63, 31);
    wait_k(10); chk_rgb("px7", 31, 63, 31);
    wait_k(16); chk("line0_last_addr", int'(vram_addr), 7);
    wait_k(17); chk("fp_ce", int'(vram_ce), 0);
    wait_k(21); chk("hs_pre", int'(lcd_hsync), 1);
    wait_k(22); chk("hs_fall", int'(lcd_hsync), 0);
    wait_k(23); chk("hs_low2", int'(lcd_hsync), 0);
    wait_k(24); chk("hs_rise", int'(lcd_hsync), 1);
    wait_k(27); chk("line1_addr0", int'(vram_addr), 0);
    wait_k(51); chk("line2_addr", int'(vram_addr), 8);
    wait_k(191); chk("last_addr", int'(vram_addr), 31); chk("last_ce", int'(vram_ce), 1);
    wait_k(200); chk("vb_pre", int'(vblank), 0);
    wait_k(201); chk("vb_rise", int'(vblank), 1);
    wait_k(252); chk("vs_pre", int'(lcd_vsync), 1);
    wait_k(253); chk("vs_fall", int'(lcd_vsync), 0);
    wait_k(302); chk("vs_last", int'(lcd_vsync), 0);
    wait_k(303); chk("vs_rise", int'(lcd_vsync), 1);
    wait_k(375); chk("vb_last", int'(vblank), 1);
    wait_k(376); chk("vb_fall", int'(vblank), 0); chk("wrap_addr", int'(vram_addr), 0);
    wait_k(377); chk("f2_fs_pre", int'(frame_start), 0);
    wait_k(378); chk("f2_fs", int'(frame_start), 1); chk_rgb("f2_px0", 31, 0, 0);

    // Mid-frame reset at counter (10,5) of the second frame
    wait_k(510);
    chk("mid_de_before", int'(lcd_de), 1);
    reset = 1'b1;
    wait_k(0);
    chk("mid_de", int'(lcd_de), 0);
    chk("mid_hsync", int'(lcd_hsync), 1);
    chk("mid_vsync", int'(lcd_vsync), 1);
    chk("mid_ce", int'(vram_ce), 0);
    chk("mid_addr", int'(vram_addr), 0);
    chk_rgb("mid", 0, 0, 0);
    reset = 1'b0;
    wait_k(1); chk("mid_k1_ce", int'(vram_ce), 1); chk("mid_k1_addr", int'(vram_addr), 0);
    wait_k(2); chk("mid_k2_de", int'(lcd_de), 0);
    wait_k(3); chk("mid_k3_de", int'(lcd_de), 1); chk("mid_k3_fs", int'(frame_start), 1);
    chk_rgb("mid_px0", 31, 0, 0);
    wait_k(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
